// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for a 16-bit byte-addressed single-port memory.
// Takes load/store requests, makes one memory access per request, returns one response.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [15:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [15:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_enable_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  input  logic [15:0]           mem_rdata_i,
  output logic                  busy_o
);

  // state  | meaning
  // IDLE   | ready for a request
  // WAIT   | wait states before the access
  // ACCESS | memory pins driven for one cycle
  // RESP   | response held until consumed
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          wr_d    = req_wr_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = req_addr_i[0];
          if (req_addr_i[0]) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        // stores report zero data; only loads capture the memory output
        if (!wr_q) rdata_d = mem_rdata_i;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == S_IDLE) & ~rst;
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_enable_o = (state_q == S_ACCESS) & ~rst;
  assign mem_wr_o     = (state_q == S_ACCESS) & wr_q & ~rst;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: one instance with no wait states and one with three,
// each attached to its own memory model and checked against a word-level reference memory.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst           [2];
  logic        req_valid     [2];
  logic        req_ready     [2];
  logic        req_wr        [2];
  logic [15:0] req_addr      [2];
  logic [15:0] req_wdata     [2];
  logic        resp_valid    [2];
  logic        resp_ready    [2];
  logic [15:0] resp_rdata    [2];
  logic        resp_err      [2];
  logic        mem_enable    [2];
  logic        mem_wr        [2];
  logic [15:0] mem_addr      [2];
  logic [15:0] mem_wdata     [2];
  logic [15:0] mem_rdata     [2];
  logic        busy          [2];

  logic [15:0] mem_arr [2][0:255];
  logic [15:0] ref_mem [2][0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wr_i(req_wr[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]),
    .mem_enable_o(mem_enable[0]), .mem_wr_o(mem_wr[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  mem_req_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wr_i(req_wr[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]),
    .mem_enable_o(mem_enable[1]), .mem_wr_o(mem_wr[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  // Memory ignores address bit 0; model covers 256 words.
  assign mem_rdata[0] = mem_arr[0][mem_addr[0][8:1]];
  assign mem_rdata[1] = mem_arr[1][mem_addr[1][8:1]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_enable[k] && mem_wr[k]) mem_arr[k][mem_addr[k][8:1]] <= mem_wdata[k];
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // One complete transaction; hold = cycles of response backpressure.
  task automatic do_req(input int k, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold);
    int          w      = wait_of(k);
    logic        misal  = addr[0];
    int          first_v = -1;
    int          en_cnt = 0;
    int          en_cyc = -1;
    logic [15:0] exp_rd;
    exp_rd = (misal || wr) ? 16'h0 : ref_mem[k][addr[8:1]];
    @(negedge clk);
    chk_val("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_wr[k] = wr; req_addr[k] = addr; req_wdata[k] = wdata;
    resp_ready[k] = 1'b0;
    for (int c = 1; c <= 40 && first_v < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // inputs after accept must be ignored
        req_valid[k] = 1'b0; req_wr[k] = 1'($urandom);
        req_addr[k] = 16'($urandom); req_wdata[k] = 16'($urandom);
      end
      if (mem_wr[k] && !mem_enable[k]) chk_val("mem_wr_without_enable", 32'd1, 32'd0);
      if (mem_enable[k]) begin
        en_cnt++;
        en_cyc = c;
        chk_val("mem_wr", 32'(mem_wr[k]), 32'(wr));
        chk_val("mem_addr", 32'(mem_addr[k]), 32'(addr));
        if (wr) chk_val("mem_wdata", 32'(mem_wdata[k]), 32'(wdata));
      end
      if (resp_valid[k]) first_v = c;
    end
    chk_val("mem_enable_pulses", 32'(en_cnt), misal ? 32'd0 : 32'd1);
    if (!misal) chk_val("access_cycle", 32'(en_cyc), 32'(1 + w));
    chk_val("resp_valid_cycle", 32'(first_v), misal ? 32'd1 : 32'(2 + w));
    if (first_v < 0) return;
    chk_val("resp_rdata", 32'(resp_rdata[k]), 32'(exp_rd));
    chk_val("resp_err", 32'(resp_err[k]), 32'(misal));
    if (!misal && wr) ref_mem[k][addr[8:1]] = wdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk_val("hold_valid", 32'(resp_valid[k]), 32'd1);
      chk_val("hold_rdata", 32'(resp_rdata[k]), 32'(exp_rd));
      chk_val("hold_err", 32'(resp_err[k]), 32'(misal));
      chk_val("hold_req_ready", 32'(req_ready[k]), 32'd0);
      chk_val("hold_mem_enable", 32'(mem_enable[k]), 32'd0);
    end
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b1;  // offered during the consuming cycle; must not be accepted
    @(negedge clk);
    req_valid[k] = 1'b0;
    chk_val("post_resp_valid", 32'(resp_valid[k]), 32'd0);
    chk_val("post_busy", 32'(busy[k]), 32'd0);
    chk_val("post_req_ready", 32'(req_ready[k]), 32'd1);
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        mem_arr[k][i] = 16'h0;
        ref_mem[k][i] = 16'h0;
      end
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_wr[k] = 1'b0;
      req_addr[k] = 16'h0; req_wdata[k] = 16'h0; resp_ready[k] = 1'b0;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_val("rst_req_ready", 32'(req_ready[k]), 32'd0);
      chk_val("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk_val("rst_resp_rdata", 32'(resp_rdata[k]), 32'd0);
      chk_val("rst_resp_err", 32'(resp_err[k]), 32'd0);
      chk_val("rst_mem_enable", 32'(mem_enable[k]), 32'd0);
      chk_val("rst_mem_wr", 32'(mem_wr[k]), 32'd0);
      chk_val("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
      chk_val("rst_mem_wdata", 32'(mem_wdata[k]), 32'd0);
      chk_val("rst_busy", 32'(busy[k]), 32'd0);
      rst[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_val("after_rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk_val("after_rst_busy", 32'(busy[k]), 32'd0);
    end

    do_req(0, 1'b1, 16'h0010, 16'hBEEF, 0);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 0);
    do_req(0, 1'b0, 16'h0011, 16'h0000, 0);
    do_req(0, 1'b1, 16'h0013, 16'h7777, 1);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 5);

    do_req(1, 1'b1, 16'h0010, 16'hCAFE, 0);
    do_req(1, 1'b0, 16'h0010, 16'h0000, 2);
    do_req(1, 1'b0, 16'h0011, 16'h0000, 0);
    do_req(1, 1'b1, 16'h0020, 16'h5A5A, 0);

    // reset in cycle 2 of a waiting store drops it entirely
    @(negedge clk);
    req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 16'h0020; req_wdata[1] = 16'h1234;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk_val("midrst_req_ready", 32'(req_ready[1]), 32'd0);
    chk_val("midrst_mem_enable", 32'(mem_enable[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    chk_val("midrst_busy", 32'(busy[1]), 32'd0);
    chk_val("midrst_mem_addr", 32'(mem_addr[1]), 32'd0);
    chk_val("midrst_mem_wdata", 32'(mem_wdata[1]), 32'd0);
    begin
      int en_seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (mem_enable[1] || resp_valid[1]) en_seen++;
      end
      chk_val("midrst_no_activity", 32'(en_seen), 32'd0);
    end
    do_req(1, 1'b0, 16'h0020, 16'h0000, 0);

    for (int n = 0; n < 120; n++) begin
      int k = n % 2;
      do_req(k, 1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
